// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   N-bit sequenced ALU between register-file read and writeback.
//   Single-cycle logic/arith ops, variable shifts iterated one bit per cycle,
//   optional iterative shift-add multiplier. Registered result with a
//   one-cycle out_valid pulse and zero/carry flags.
//
//   Build option: define ALU_SEQ_MUL_EN to enable opcode 9 (MUL). Without it,
//   opcode 9 behaves as an undefined opcode and no multiplier state exists.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   synchronous reset, active-high
//   A, B       in   operands (B[SW-1:0] is the shift amount)
//   opcode     in   operation select
//   in_valid   in   operands/opcode valid
//   in_ready   out  high only in IDLE; transfer on in_valid && in_ready
//   out        out  registered result
//   out_valid  out  one-cycle pulse when out/flags update for an accepted op
//   flag_z     out  out == 0 for the last completed op
//   flag_c     out  carry / borrow / last shifted-out bit for the last op
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accepting; single-cycle ops complete on the accept edge
// SHIFT | shifting latched operand one bit per cycle, cnt counts down
// MUL   | shift-add multiply, one multiplier bit per cycle (ALU_SEQ_MUL_EN)
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int N  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   opcode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         flag_z,
    output logic         flag_c
);

    // One extra bit so the counter can hold N for the multiplier.
    localparam int CW = SW + 1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t        state, state_n;
    logic [N-1:0]  out_n, sh, sh_n, sh_step;
    logic          valid_n, z_n, c_n, upd, sh_left, left_n, sh_bit;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] amt;
    logic [N:0]    sum, diff;

`ifdef ALU_SEQ_MUL_EN
    logic [2*N-1:0] prod, prod_n, prod_step;
    logic [N-1:0]   mcand, mcand_n;
    logic [N:0]     mul_add;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            flag_z    <= 1'b1;
            flag_c    <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            sh_left   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod      <= '0;
            mcand     <= '0;
`endif
        end else begin
            state     <= state_n;
            out       <= out_n;
            out_valid <= valid_n;
            flag_z    <= z_n;
            flag_c    <= c_n;
            sh        <= sh_n;
            cnt       <= cnt_n;
            sh_left   <= left_n;
`ifdef ALU_SEQ_MUL_EN
            prod      <= prod_n;
            mcand     <= mcand_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        out_n    = out;
        valid_n  = 1'b0;
        z_n      = flag_z;
        c_n      = flag_c;
        upd      = 1'b0;
        sh_n     = sh;
        cnt_n    = cnt;
        left_n   = sh_left;
        in_ready = (state == ST_IDLE);
        amt      = B[SW-1:0];
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};   // bit N is the borrow
        sh_step  = sh_left ? {sh[N-2:0], 1'b0} : {sh[N-1], sh[N-1:1]};
        sh_bit   = sh_left ? sh[N-1] : sh[0];
`ifdef ALU_SEQ_MUL_EN
        prod_n    = prod;
        mcand_n   = mcand;
        mul_add   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step = {mul_add, prod[N-1:1]};
`endif

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    valid_n = 1'b1;
                    case (opcode)
                        4'd0: begin out_n = sum[N-1:0];  c_n = sum[N];  upd = 1'b1; end
                        4'd1: begin out_n = A ^ B;       c_n = 1'b0;    upd = 1'b1; end
                        4'd2: begin out_n = A | B;       c_n = 1'b0;    upd = 1'b1; end
                        4'd3: begin out_n = A & B;       c_n = 1'b0;    upd = 1'b1; end
                        4'd4: begin out_n = {{(N-1){1'b0}}, A == B}; c_n = 1'b0; upd = 1'b1; end
                        4'd5: begin out_n = {{(N-1){1'b0}}, A < B};  c_n = 1'b0; upd = 1'b1; end
                        4'd8: begin out_n = diff[N-1:0]; c_n = diff[N]; upd = 1'b1; end
                        4'd6, 4'd7: begin
                            if (amt == '0) begin
                                out_n = A;
                                c_n   = 1'b0;
                                upd   = 1'b1;
                            end else begin
                                valid_n = 1'b0;
                                sh_n    = A;
                                cnt_n   = CW'(amt);
                                left_n  = (opcode == 4'd6);
                                state_n = ST_SHIFT;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        4'd9: begin
                            valid_n = 1'b0;
                            prod_n  = {{N{1'b0}}, B};
                            mcand_n = A;
                            cnt_n   = CW'(N);
                            state_n = ST_MUL;
                        end
`endif
                        // Undefined opcode: pulse out_valid, leave result/flags.
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_n  = sh_step;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    out_n   = sh_step;
                    c_n     = sh_bit;
                    upd     = 1'b1;
                    valid_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                prod_n = prod_step;
                cnt_n  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    out_n   = prod_step[N-1:0];
                    c_n     = |prod_step[2*N-1:N];
                    upd     = 1'b1;
                    valid_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        if (upd) z_n = (out_n == '0);
    end

endmodule
